// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and types for the TDM transmitter.
//   TDM_SLOTS / TDM_SLOT_BITS : frame geometry (4 slots of 32 bits)
//   TDM_K_W                   : width of the frame bit counter
//   TDM_SLOT_W / TDM_BIT_W    : slot index and bit-within-slot widths
//   tdm_state_t               : transmitter FSM states
package tdm_pkg;

    localparam int TDM_SLOTS      = 4;
    localparam int TDM_SLOT_BITS  = 32;
    localparam int TDM_FRAME_BITS = TDM_SLOTS * TDM_SLOT_BITS;
    localparam int TDM_K_W        = $clog2(TDM_FRAME_BITS);
    localparam int TDM_SLOT_W     = $clog2(TDM_SLOTS);
    localparam int TDM_BIT_W      = $clog2(TDM_SLOT_BITS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tdm_state_t;

endpackage

// File: rtl/tdm_bclk_gen.sv
// tdm_bclk_gen: bit clock divider for the TDM transmitter.
// bclk is low for BCLK_DIV clk cycles, then high for BCLK_DIV cycles.
// While en is low the divider sits in its reset phase (counter 0, bclk low),
// so the first enabled cycle is the start of a low half-period.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   en         run enable
//   bclk       bit clock
//   fall/rise  one-cycle strobes, high in the clk cycle just before bclk
//              falls / rises (i.e. the transition happens on the next edge)
module tdm_bclk_gen #(
    parameter int BCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bclk,
    output logic fall,
    output logic rise
);

    localparam int CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == CNT_W'(BCLK_DIV - 1));
    assign fall = en & wrap & bclk;
    assign rise = en & wrap & ~bclk;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt  <= '0;
            bclk <= 1'b0;
        end else if (wrap) begin
            cnt  <= '0;
            bclk <= ~bclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_tx.sv
// tdm_tx: four-channel TDM serial transmitter.
// Captures sample_in0..3 on each rising edge of sample_clk (detected in the
// clk domain) and sends them MSB-first in a 4 x 32-bit slot frame. Words
// narrower than 32 bits are padded with zeros at the end of each slot.
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   sample_clk            sample-rate clock, rising edge loads the inputs
//   sample_in0..3         signed channel words
//   bclk, lrck, sdout     TDM bit clock, frame sync (k == 0), serial data
//   underrun              sticky flag for a frame start with no new samples
// Build option: define TDM_TX_UNDERRUN_EN to build the underrun detector;
// otherwise underrun is tied low (stale frames are still retransmitted).
module tdm_tx
    import tdm_pkg::*;
#(
    parameter int W        = 16,
    parameter int BCLK_DIV = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clk,
    input  logic signed [W-1:0] sample_in0,
    input  logic signed [W-1:0] sample_in1,
    input  logic signed [W-1:0] sample_in2,
    input  logic signed [W-1:0] sample_in3,
    output logic                bclk,
    output logic                lrck,
    output logic                sdout,
    output logic                underrun
);

    // Bit of a slot word at position j (0 = MSB); zero past the word width.
    function automatic logic slot_bit(input logic signed [W-1:0] word,
                                      input logic [TDM_BIT_W-1:0] j);
        logic [W-1:0] sh;
        sh = $unsigned(word) << j;
        return sh[W-1];
    endfunction

    logic                sc_q;
    logic                sc_edge;
    logic signed [W-1:0] in_w     [TDM_SLOTS];
    logic signed [W-1:0] hold_q   [TDM_SLOTS];
    logic signed [W-1:0] shadow_q [TDM_SLOTS];
    logic signed [W-1:0] shadow_d [TDM_SLOTS];
    logic [TDM_K_W-1:0]  k_q;
    logic [TDM_K_W-1:0]  k_d;
    tdm_state_t          state_q;
    tdm_state_t          state_d;
    logic                launch;
    logic                frame_start;
    logic                sdout_d;
    logic                lrck_d;
    logic                bclk_fall;
    logic                unused_rise;

    assign in_w[0] = sample_in0;
    assign in_w[1] = sample_in1;
    assign in_w[2] = sample_in2;
    assign in_w[3] = sample_in3;

    // Edge detect: sc_q is the previous-cycle sample_clk.
    assign sc_edge = sample_clk & ~sc_q;

    always_ff @(posedge clk) begin
        sc_q <= sample_clk;
    end

    tdm_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == RUN),
        .bclk (bclk),
        .fall (bclk_fall),
        .rise (unused_rise)
    );

    // Next state, bit launch and frame-start decode. A launch updates k and
    // the serial outputs together with the falling bclk (or RUN entry).
    always_comb begin
        state_d     = state_q;
        launch      = 1'b0;
        frame_start = 1'b0;
        k_d         = k_q;
        case (state_q)
            IDLE: begin
                if (sc_edge) begin
                    state_d     = RUN;
                    launch      = 1'b1;
                    frame_start = 1'b1;
                    k_d         = '0;
                end
            end
            RUN: begin
                if (bclk_fall) begin
                    launch      = 1'b1;
                    k_d         = k_q + 1'b1;
                    frame_start = (k_d == '0);
                end
            end
            default: state_d = IDLE;
        endcase

        // An edge coinciding with frame start forwards the live inputs so the
        // new samples are not held back a whole frame.
        for (int i = 0; i < TDM_SLOTS; i++) begin
            shadow_d[i] = shadow_q[i];
            if (frame_start) begin
                shadow_d[i] = sc_edge ? in_w[i] : hold_q[i];
            end
        end

        sdout_d = slot_bit(shadow_d[k_d[TDM_K_W-1 -: TDM_SLOT_W]],
                           k_d[TDM_BIT_W-1:0]);
        lrck_d  = (k_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            lrck    <= 1'b0;
            sdout   <= 1'b0;
            for (int i = 0; i < TDM_SLOTS; i++) begin
                hold_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (launch) begin
                k_q   <= k_d;
                lrck  <= lrck_d;
                sdout <= sdout_d;
            end
            for (int i = 0; i < TDM_SLOTS; i++) begin
                shadow_q[i] <= shadow_d[i];
                if (sc_edge) begin
                    hold_q[i] <= in_w[i];
                end
            end
        end
    end

`ifdef TDM_TX_UNDERRUN_EN
    logic fresh_q;
    logic stale;
    logic underrun_q;

    // A frame start in RUN with nothing new in holding and no forwarded edge.
    assign stale = frame_start && (state_q == RUN) && !fresh_q && !sc_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            fresh_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (frame_start) begin
                fresh_q <= 1'b0;
            end else if (sc_edge) begin
                fresh_q <= 1'b1;
            end
            if (stale) begin
                underrun_q <= 1'b1;
            end
        end
    end

    assign underrun = underrun_q;
`else
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_tx.sv
// tb_tdm_tx: self-checking bench for tdm_tx (W = 16, BCLK_DIV = 2).
// A monitor deserializes sdout on rising bclk, aligns frames on lrck and
// compares each frame against the expected-frame queue filled as stimulus
// is driven. Sequences cover idle, table vectors, a continuous stream,
// stale frames, reset mid-frame and an edge aligned to a frame start.
module tb_tdm_tx;

    localparam int W     = 16;
    localparam int FRAME = 512;

`ifdef TDM_TX_UNDERRUN_EN
    localparam logic UR_EXP = 1'b1;
`else
    localparam logic UR_EXP = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] c0, c1, c2, c3;
        logic [31:0] e0, e1, e2, e3;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                sample_clk = 1'b0;
    logic signed [W-1:0] sample_in0 = '0;
    logic signed [W-1:0] sample_in1 = '0;
    logic signed [W-1:0] sample_in2 = '0;
    logic signed [W-1:0] sample_in3 = '0;
    logic                bclk, lrck, sdout, underrun;

    int nchk = 0;
    int nfail = 0;
    int frames_pushed = 0;
    int frames_checked = 0;

    logic [127:0] exp_q[$];

    tdm_tx #(
        .W        (W),
        .BCLK_DIV (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_clk (sample_clk),
        .sample_in0 (sample_in0),
        .sample_in1 (sample_in1),
        .sample_in2 (sample_in2),
        .sample_in3 (sample_in3),
        .bclk       (bclk),
        .lrck       (lrck),
        .sdout      (sdout),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: deserialize on bclk rising, pop the expectation at frame start.
    logic         bclk_prev = 1'b0;
    logic [127:0] fbits = '0;
    int           bitcnt = 0;
    logic         have_exp = 1'b0;
    logic [127:0] cur_exp = '0;

    always @(negedge clk) begin
        if (rst) begin
            bitcnt   = 0;
            have_exp = 1'b0;
        end else if (bclk && !bclk_prev) begin
            if (lrck) begin
                bitcnt   = 0;
                fbits    = '0;
                have_exp = (exp_q.size() > 0);
                if (have_exp) cur_exp = exp_q.pop_front();
            end
            fbits = {fbits[126:0], sdout};
            bitcnt++;
            if (bitcnt == 128 && have_exp) begin
                for (int s = 0; s < 4; s++) begin
                    check($sformatf("frame_slot%0d", s), fbits[127-32*s -: 32],
                          cur_exp[127-32*s -: 32]);
                end
                have_exp = 1'b0;
                frames_checked++;
            end
        end
        bclk_prev = bclk;
    end

    task automatic drive_edge(input logic [15:0] c0, c1, c2, c3);
        sample_in0 = c0;
        sample_in1 = c1;
        sample_in2 = c2;
        sample_in3 = c3;
        sample_clk = 1'b1;
        @(negedge clk);
        sample_clk = 1'b0;
    endtask

    task automatic push_exp(input logic [127:0] f);
        exp_q.push_back(f);
        frames_pushed++;
    endtask

    // Returns at the negedge right after the next lrck rise.
    task automatic wait_frame_start();
        logic prev;
        logic found;
        prev  = lrck;
        found = 1'b0;
        for (int c = 0; c < FRAME + 64 && !found; c++) begin
            @(negedge clk);
            if (lrck && !prev) found = 1'b1;
            prev = lrck;
        end
        check("frame_start_seen", {31'd0, found}, 32'd1);
    endtask

    // Mid-frame edge: samples go out in the following frame.
    task automatic send(input logic [15:0] c0, c1, c2, c3, input logic [127:0] f);
        repeat (100) @(negedge clk);
        push_exp(f);
        drive_edge(c0, c1, c2, c3);
        wait_frame_start();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[5];
    logic [1:0] ph_exp[5];

    initial begin
        vecs[0] = '{16'h8001, 16'h7FFE, 16'h00FF, 16'hFF00,
                    32'h8001_0000, 32'h7FFE_0000, 32'h00FF_0000, 32'hFF00_0000};
        vecs[1] = '{16'h0000, 16'hFFFF, 16'hAAAA, 16'h5555,
                    32'h0000_0000, 32'hFFFF_0000, 32'hAAAA_0000, 32'h5555_0000};
        vecs[2] = '{16'h7FFF, 16'h8000, 16'h0001, 16'hFFFE,
                    32'h7FFF_0000, 32'h8000_0000, 32'h0001_0000, 32'hFFFE_0000};
        vecs[3] = '{16'h1357, 16'h2468, 16'h9BDF, 16'hECA8,
                    32'h1357_0000, 32'h2468_0000, 32'h9BDF_0000, 32'hECA8_0000};
        vecs[4] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000,
                    32'hFFFF_0000, 32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000};
        // {lrck, bclk} over the first five cycles of RUN
        ph_exp[0] = 2'b10; ph_exp[1] = 2'b10; ph_exp[2] = 2'b11;
        ph_exp[3] = 2'b11; ph_exp[4] = 2'b00;

        // Reset and idle
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check("idle_outputs", {28'd0, bclk, lrck, sdout, underrun}, 32'd0);
        end

        // Table vectors; entry 0 starts the transmitter
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                repeat (10) @(negedge clk);
                push_exp({vecs[0].e0, vecs[0].e1, vecs[0].e2, vecs[0].e3});
                drive_edge(vecs[0].c0, vecs[0].c1, vecs[0].c2, vecs[0].c3);
                check("run_entry_sdout", {31'd0, sdout}, 32'd1);
                for (int p = 0; p < 5; p++) begin
                    if (p > 0) @(negedge clk);
                    check($sformatf("run_entry_phase%0d", p), {30'd0, lrck, bclk},
                          {30'd0, ph_exp[p]});
                end
            end else begin
                send(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3,
                     {vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3});
            end
        end

        // Continuous stream, incrementing ch0
        for (int n = 0; n < 4; n++) begin
            send(16'(n), 16'h0, 16'h0, 16'h0, {16'(n), 16'h0, 96'd0});
        end
        check("stream_underrun", {31'd0, underrun}, 32'd0);

        // No more edges: the next frame repeats ch0 = 3
        push_exp({16'd3, 16'h0, 96'd0});
        repeat (4) @(negedge clk);
        check("underrun_before_stale", {31'd0, underrun}, 32'd0);
        wait_frame_start();
        repeat (4) @(negedge clk);
        check("underrun_at_stale", {31'd0, underrun}, {31'd0, UR_EXP});
        wait_frame_start();
        check("underrun_held", {31'd0, underrun}, {31'd0, UR_EXP});
        check("frames_before_reset", 32'(frames_checked), 32'(frames_pushed));

        // Reset at k = 50 (200 clk cycles into the frame)
        repeat (200) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_midframe_outputs", {28'd0, bclk, lrck, sdout, underrun}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("post_reset_idle", {28'd0, bclk, lrck, sdout, underrun}, 32'd0);
        end

        // Restart with new data
        push_exp({32'hA5A5_0000, 32'hC3C3_0000, 32'h0F0F_0000, 32'hF00F_0000});
        drive_edge(16'hA5A5, 16'hC3C3, 16'h0F0F, 16'hF00F);
        check("restart_entry", {29'd0, bclk, lrck, sdout}, 32'b011);

        // Edge landing exactly on the next frame-start clock edge
        repeat (FRAME - 1) @(negedge clk);
        push_exp({32'h0001_0000, 32'h1234_0000, 32'hABCD_0000, 32'h8000_0000});
        drive_edge(16'h0001, 16'h1234, 16'hABCD, 16'h8000);

        for (int c = 0; c < 3 * FRAME && frames_checked < frames_pushed; c++) begin
            @(negedge clk);
        end
        check("all_frames_checked", 32'(frames_checked), 32'(frames_pushed));
        check("forward_underrun", {31'd0, underrun}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/tdm_tx.md
# tdm_tx

Four-channel TDM serial transmitter driving the codec DAC data line. Captures the four parallel `sample_out*` words produced by the active audio core on each `sample_clk` rising edge, and shifts them MSB-first into a 4-slot TDM frame with generated bit clock and frame sync. It is the transmit end of the sample bus that the cores consume from the codec receiver.

## Interface
- `W`, 16: sample width, signed two's complement, 2 ≤ W ≤ 32.
- `BCLK_DIV`, 2: `clk` cycles per `bclk` half-period, ≥ 1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `sample_clk`  in  1  sample-rate clock; only its rising edge is used, detected in the `clk` domain.
- `sample_in0`..`sample_in3`  in  W each  channel words, valid when the `sample_clk` edge is detected.
- `bclk`  out  1  TDM bit clock.
- `lrck`  out  1  frame sync, one `bclk` period wide.
- `sdout`  out  1  serial data.
- `underrun`  out  1  sticky stale-frame flag (see Configuration).

## Operation
- Edge detect: `sc_q` registers `sample_clk`; edge = `sample_clk & ~sc_q`. On an edge, the holding register loads all four inputs and sets `fresh`.
- FSM:
  - IDLE (reset state): `bclk`, `lrck` and `sdout` are 0; divider is held. The first edge moves to RUN.
  - RUN: free-running frames. Leaves RUN only on `rst`.
- Frame: 4 slots × 32 bits = 128 bits; bit counter `k` runs 0..127 and wraps.
- Launch: each falling `bclk` transition (and RUN entry) updates `k` and `sdout`.
  - `slot = k/32`, `j = k%32`.
  - `sdout = shadow[slot][W-1-j]` for `j < W`, otherwise 0.
  - `lrck = (k == 0)`.
- Frame start (`k` wraps to 0, or RUN entry): the shadow register loads from the holding register and `fresh` clears.
  - If an edge occurs in the same cycle, shadow loads the incoming inputs directly (forwarding) and the frame counts as fresh.
- Stale frame: a frame start with `fresh == 0` retransmits the previous shadow contents unchanged.
- Reset mid-frame: next cycle all outputs are 0, state is IDLE, holding/shadow/`fresh`/`underrun`/`k` are cleared, and any partial frame is dropped.
- Edges arriving faster than frames: holding is overwritten; only the latest value is sent.

## Timing
- Reset values: `bclk`=0, `lrck`=0, `sdout`=0, `underrun`=0.
- Edge detected in the first `clk` edge that samples `sample_clk` high; holding is valid the cycle after.
- RUN entry happens in the cycle after the edge is detected. In that cycle, `bclk` is low, `lrck`=1, and `sdout` is ch0 MSB.
- `bclk` is low for `BCLK_DIV` cycles, then high for `BCLK_DIV` cycles, repeating. Data changes only with `bclk` falling, so the receiver samples on `bclk` rising.
- Frame period: 256·`BCLK_DIV` `clk` cycles. Defaults give 512.
- Input-to-first-bit latency: from the edge to the next frame start, at most one frame plus 2 cycles.

## Configuration
- `TDM_TX_UNDERRUN_EN`
  - Defined: `underrun` is set at any stale frame start in RUN and held until `rst`.
  - Undefined: `underrun` is tied 0 and the detection logic is not built. Stale-frame retransmission is unchanged.

## Structure
- Package `tdm_pkg`:
  - `TDM_SLOTS` = 4, `TDM_SLOT_BITS` = 32.
  - `tdm_state_t` enum {IDLE, RUN}.
  - Bit-counter width `$clog2(TDM_SLOTS*TDM_SLOT_BITS)`.
- Sub-module `tdm_bclk_gen`:
  - Divider producing `bclk`, plus one-cycle `fall`/`rise` strobes.
  - Enable input; held in its reset phase while disabled.
- Top level: edge detect, holding/shadow registers, FSM, bit counter, slot/bit mux.

## Test plan
- Reset/idle: `rst` for 4 cycles, `sample_clk` low for 100 cycles → `bclk`/`lrck`/`sdout`/`underrun` all 0 throughout.
- Basic frame: defaults, one edge with inputs 0x8001, 0x7FFE, 0x00FF, 0xFF00 → `lrck` high for 4 cycles at RUN entry. Deserialized slots on `bclk` rising are 0x8001_0000, 0x7FFE_0000, 0x00FF_0000, 0xFF00_0000.
- Continuous stream: edges every 512 cycles with incrementing ch0 0,1,2,… → each frame carries the next value, no repeats, `underrun` stays 0.
- Underrun (macro defined): stop edges after frame 3 → frames 4+ repeat frame-3 data; `underrun` rises at frame-4 start and holds. With macro undefined, `underrun` stays 0.
- Forwarding: edge aligned exactly to a frame-start cycle with ch1 = 0x1234 → that frame's slot 1 = 0x1234_0000, no underrun.
- Reset mid-frame: assert `rst` at `k`=50 → outputs 0 the next cycle. After release and a new edge, the frame restarts at `k`=0 with new data only.
